// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the in-order pipeline.
// Picks the EX operand bypass source from NUM_STG post-EX stages. It also
// stalls IF/ID and injects EX bubbles while a load result is not yet
// forwardable. A saturating stall counter and a sticky illegal-forward
// flag are kept for debug.
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_STG  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(NUM_STG + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic                        ex_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_RegWrite,
    input  logic                        ex_MemRead,
    input  logic [NUM_STG*REG_AW-1:0]   stg_rd,
    input  logic [NUM_STG-1:0]          stg_RegWrite,
    input  logic [NUM_STG-1:0]          stg_MemRead,
    input  logic                        flush,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall,
    output logic                        bubble,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic                        fwd_err
);

    localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 fwd_err_q, fwd_err_d;
    logic                 stall_c;
    logic [NUM_SRC-1:0]   op_bad;
    logic [SEL_W-1:0]     op_need [NUM_SRC];
    logic [SEL_W-1:0]     need_max;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] ex_src;
        logic [REG_AW-1:0] id_src;
        logic [SEL_W-1:0]  sel;
        logic              bad;
        logic [SEL_W-1:0]  need;

        assign ex_src = ex_rs[gi*REG_AW +: REG_AW];
        assign id_src = id_rs[gi*REG_AW +: REG_AW];

        // Bypass select: scan far-to-near so the nearest matching stage wins.
        always_comb begin
            sel = '0;
            bad = 1'b0;
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (stg_RegWrite[k] && (stg_rd[k*REG_AW +: REG_AW] != '0) &&
                    (stg_rd[k*REG_AW +: REG_AW] == ex_src)) begin
                    sel = SEL_W'(k + 1);
                    bad = stg_MemRead[k] && (k < LOAD_LAT);
                end
            end
            if (!ex_valid) begin
                sel = '0;
                bad = 1'b0;
            end
        end

        // Stall cycles this ID operand needs before a pending load is forwardable.
        always_comb begin
            need = '0;
            if (id_rs_used[gi] && (id_src != '0)) begin
                if (ex_valid && ex_RegWrite && ex_MemRead && (ex_rd == id_src)) begin
                    need = SEL_W'(LOAD_LAT);
                end
                for (int j = 0; j < NUM_STG; j++) begin
                    if (stg_RegWrite[j] && stg_MemRead[j] &&
                        (stg_rd[j*REG_AW +: REG_AW] == id_src) &&
                        (LOAD_LAT - 1 - j > 0) &&
                        (LOAD_LAT - 1 - j > int'(need))) begin
                        need = SEL_W'(LOAD_LAT - 1 - j);
                    end
                end
            end
        end

        assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
        assign op_bad[gi]                 = bad;
        assign op_need[gi]                = need;
    end

    // Worst-case stall demand over all operands of the ID instruction.
    always_comb begin
        need_max = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (op_need[i] > need_max) begin
                need_max = op_need[i];
            end
        end
        if (!id_valid) begin
            need_max = '0;
        end
    end

    // Stall FSM: IDLE covers the first stall cycle (Mealy), STALL the rest.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (need_max != '0) begin
                    stall_c = 1'b1;
                    if (need_max > ONE) begin
                        state_d = STALL;
                        rem_d   = need_max - ONE;
                    end
                end
            end
            STALL: begin
                stall_c = 1'b1;
                rem_d   = rem_q - ONE;
                if (rem_q == ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        if (flush) begin
            stall_c = 1'b0;
            state_d = IDLE;
            rem_d   = '0;
        end
    end

    // Saturating stall counter and sticky illegal-forward flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        fwd_err_d = fwd_err_q | (|op_bad);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            fwd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_err_q   <= fwd_err_d;
        end
    end

    assign stall     = stall_c;
    assign bubble    = stall_c;
    assign stall_cnt = stall_cnt_q;
    assign fwd_err   = fwd_err_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instance a uses default parameters,
// instance b uses NUM_STG=3, LOAD_LAT=2, CNT_W=4.
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance a signals (NUM_STG=2, LOAD_LAT=1, CNT_W=16)
    logic        a_id_valid;
    logic [9:0]  a_id_rs;
    logic [1:0]  a_id_rs_used;
    logic        a_ex_valid;
    logic [9:0]  a_ex_rs;
    logic [4:0]  a_ex_rd;
    logic        a_ex_RegWrite;
    logic        a_ex_MemRead;
    logic [9:0]  a_stg_rd;
    logic [1:0]  a_stg_RegWrite;
    logic [1:0]  a_stg_MemRead;
    logic        a_flush;
    logic [3:0]  a_fwd_sel;
    logic        a_stall;
    logic        a_bubble;
    logic [15:0] a_stall_cnt;
    logic        a_fwd_err;

    // Instance b signals (NUM_STG=3, LOAD_LAT=2, CNT_W=4)
    logic        b_id_valid;
    logic [9:0]  b_id_rs;
    logic [1:0]  b_id_rs_used;
    logic        b_ex_valid;
    logic [9:0]  b_ex_rs;
    logic [4:0]  b_ex_rd;
    logic        b_ex_RegWrite;
    logic        b_ex_MemRead;
    logic [14:0] b_stg_rd;
    logic [2:0]  b_stg_RegWrite;
    logic [2:0]  b_stg_MemRead;
    logic        b_flush;
    logic [3:0]  b_fwd_sel;
    logic        b_stall;
    logic        b_bubble;
    logic [3:0]  b_stall_cnt;
    logic        b_fwd_err;

    fwd_hazard_ctrl dut_a (
        .clk(clk), .reset(reset),
        .id_valid(a_id_valid), .id_rs(a_id_rs), .id_rs_used(a_id_rs_used),
        .ex_valid(a_ex_valid), .ex_rs(a_ex_rs), .ex_rd(a_ex_rd),
        .ex_RegWrite(a_ex_RegWrite), .ex_MemRead(a_ex_MemRead),
        .stg_rd(a_stg_rd), .stg_RegWrite(a_stg_RegWrite), .stg_MemRead(a_stg_MemRead),
        .flush(a_flush), .fwd_sel(a_fwd_sel), .stall(a_stall), .bubble(a_bubble),
        .stall_cnt(a_stall_cnt), .fwd_err(a_fwd_err)
    );

    fwd_hazard_ctrl #(.NUM_STG(3), .LOAD_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .id_valid(b_id_valid), .id_rs(b_id_rs), .id_rs_used(b_id_rs_used),
        .ex_valid(b_ex_valid), .ex_rs(b_ex_rs), .ex_rd(b_ex_rd),
        .ex_RegWrite(b_ex_RegWrite), .ex_MemRead(b_ex_MemRead),
        .stg_rd(b_stg_rd), .stg_RegWrite(b_stg_RegWrite), .stg_MemRead(b_stg_MemRead),
        .flush(b_flush), .fwd_sel(b_fwd_sel), .stall(b_stall), .bubble(b_bubble),
        .stall_cnt(b_stall_cnt), .fwd_err(b_fwd_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a;
        a_id_valid = 0; a_id_rs = '0; a_id_rs_used = '0;
        a_ex_valid = 0; a_ex_rs = '0; a_ex_rd = '0;
        a_ex_RegWrite = 0; a_ex_MemRead = 0;
        a_stg_rd = '0; a_stg_RegWrite = '0; a_stg_MemRead = '0;
        a_flush = 0;
    endtask

    task automatic clear_b;
        b_id_valid = 0; b_id_rs = '0; b_id_rs_used = '0;
        b_ex_valid = 0; b_ex_rs = '0; b_ex_rd = '0;
        b_ex_RegWrite = 0; b_ex_MemRead = 0;
        b_stg_rd = '0; b_stg_RegWrite = '0; b_stg_MemRead = '0;
        b_flush = 0;
    endtask

    // b: load x9 sitting in EX with an ID consumer on operand 0
    task automatic b_load_in_ex;
        b_id_valid = 1; b_id_rs = {5'd0, 5'd9}; b_id_rs_used = 2'b01;
        b_ex_valid = 1; b_ex_rd = 5'd9; b_ex_RegWrite = 1; b_ex_MemRead = 1;
        b_stg_rd = '0; b_stg_RegWrite = '0; b_stg_MemRead = '0;
    endtask

    initial begin
        reset = 1;
        clear_a;
        clear_b;
        repeat (2) tick;
        reset = 0;

        // Reset state
        @(negedge clk);
        check("rst_a_stall", a_stall, 0);
        check("rst_a_bubble", a_bubble, 0);
        check("rst_a_cnt", a_stall_cnt, 0);
        check("rst_a_err", a_fwd_err, 0);
        check("rst_b_cnt", b_stall_cnt, 0);
        check("rst_a_sel", a_fwd_sel, 0);
        tick;

        // Forwarding: both stages write x5, nearest (stg0) wins
        a_ex_valid = 1; a_ex_rs = {5'd5, 5'd5};
        a_stg_rd = {5'd5, 5'd5}; a_stg_RegWrite = 2'b11;
        @(negedge clk);
        check("fwd_nearest", a_fwd_sel, 4'b0101);
        tick;
        a_stg_RegWrite = 2'b10;
        @(negedge clk);
        check("fwd_far", a_fwd_sel, 4'b1010);
        tick;
        a_ex_rs = {5'd6, 5'd5}; a_stg_rd = {5'd5, 5'd6}; a_stg_RegWrite = 2'b11;
        @(negedge clk);
        check("fwd_mixed", a_fwd_sel, 4'b0110);
        tick;
        a_ex_rs = {5'd0, 5'd5}; a_stg_rd = {5'd0, 5'd5};
        @(negedge clk);
        check("fwd_x0", a_fwd_sel, 4'b0001);
        tick;
        a_ex_valid = 0;
        @(negedge clk);
        check("fwd_invalid", a_fwd_sel, 0);
        check("fwd_noerr", a_fwd_err, 0);
        tick;

        // Load-use, LOAD_LAT=1: load x7 in EX, ID operand 1 reads x7
        clear_a;
        a_id_valid = 1; a_id_rs = {5'd7, 5'd1}; a_id_rs_used = 2'b11;
        a_ex_valid = 1; a_ex_rd = 5'd7; a_ex_RegWrite = 1; a_ex_MemRead = 1;
        @(negedge clk);
        check("lu1_stall", a_stall, 1);
        check("lu1_bubble", a_bubble, 1);
        check("lu1_cnt0", a_stall_cnt, 0);
        tick;
        a_ex_valid = 0; a_ex_RegWrite = 0; a_ex_MemRead = 0;
        a_stg_rd = {5'd0, 5'd7}; a_stg_RegWrite = 2'b01; a_stg_MemRead = 2'b01;
        @(negedge clk);
        check("lu1_release", a_stall, 0);
        check("lu1_rel_bub", a_bubble, 0);
        check("lu1_cnt1", a_stall_cnt, 1);
        tick;
        clear_a;
        a_id_valid = 1; a_id_rs = {5'd7, 5'd1}; a_id_rs_used = 2'b01;
        a_ex_valid = 1; a_ex_rd = 5'd7; a_ex_RegWrite = 1; a_ex_MemRead = 1;
        @(negedge clk);
        check("lu1_unused", a_stall, 0);
        tick;
        a_id_rs_used = 2'b11; a_id_valid = 0;
        @(negedge clk);
        check("lu1_idinv", a_stall, 0);
        tick;
        a_id_valid = 1; a_id_rs = {5'd0, 5'd1}; a_ex_rd = 5'd0;
        @(negedge clk);
        check("lu1_x0", a_stall, 0);
        tick;
        a_id_rs = {5'd7, 5'd1}; a_ex_rd = 5'd7; a_ex_MemRead = 0;
        @(negedge clk);
        check("lu1_nonload", a_stall, 0);
        check("lu1_cnt_hold", a_stall_cnt, 1);
        tick;

        // Legal forward from load in stg1, then illegal forward from stg0
        clear_a;
        a_ex_valid = 1; a_ex_rs = {5'd0, 5'd3};
        a_stg_rd = {5'd3, 5'd0}; a_stg_RegWrite = 2'b10; a_stg_MemRead = 2'b10;
        @(negedge clk);
        check("fwd_ld_legal", a_fwd_sel, 4'b0010);
        tick;
        @(negedge clk);
        check("err_legal", a_fwd_err, 0);
        tick;
        a_stg_rd = {5'd0, 5'd3}; a_stg_RegWrite = 2'b01; a_stg_MemRead = 2'b01;
        @(negedge clk);
        check("fwd_ld_illegal", a_fwd_sel, 4'b0001);
        check("err_not_yet", a_fwd_err, 0);
        tick;
        clear_a;
        @(negedge clk);
        check("err_set", a_fwd_err, 1);
        repeat (3) tick;
        @(negedge clk);
        check("err_sticky", a_fwd_err, 1);
        tick;

        // b: load x9 in EX, LOAD_LAT=2 -> 2 stall cycles
        b_load_in_ex;
        @(negedge clk);
        check("lu2_c0_stall", b_stall, 1);
        check("lu2_c0_cnt", b_stall_cnt, 0);
        tick;
        b_ex_valid = 0; b_ex_RegWrite = 0; b_ex_MemRead = 0;
        b_stg_rd = {5'd0, 5'd0, 5'd9}; b_stg_RegWrite = 3'b001; b_stg_MemRead = 3'b001;
        @(negedge clk);
        check("lu2_c1_stall", b_stall, 1);
        check("lu2_c1_bubble", b_bubble, 1);
        check("lu2_c1_cnt", b_stall_cnt, 1);
        tick;
        b_stg_rd = {5'd0, 5'd9, 5'd0}; b_stg_RegWrite = 3'b010; b_stg_MemRead = 3'b010;
        @(negedge clk);
        check("lu2_c2_stall", b_stall, 0);
        check("lu2_c2_cnt", b_stall_cnt, 2);
        tick;
        // Load x9 already in stg0 -> one stall cycle
        b_stg_rd = {5'd0, 5'd0, 5'd9}; b_stg_RegWrite = 3'b001; b_stg_MemRead = 3'b001;
        @(negedge clk);
        check("lu2s0_stall", b_stall, 1);
        tick;
        b_stg_rd = {5'd0, 5'd9, 5'd0}; b_stg_RegWrite = 3'b010; b_stg_MemRead = 3'b010;
        @(negedge clk);
        check("lu2s0_release", b_stall, 0);
        check("lu2s0_cnt", b_stall_cnt, 3);
        tick;

        // Flush in second stall cycle
        b_load_in_ex;
        @(negedge clk);
        check("fl_c0_stall", b_stall, 1);
        tick;
        b_ex_valid = 0; b_ex_RegWrite = 0; b_ex_MemRead = 0;
        b_stg_rd = {5'd0, 5'd0, 5'd9}; b_stg_RegWrite = 3'b001; b_stg_MemRead = 3'b001;
        b_flush = 1;
        @(negedge clk);
        check("fl_c1_stall", b_stall, 0);
        check("fl_c1_bubble", b_bubble, 0);
        tick;
        b_flush = 0;
        b_stg_rd = {5'd0, 5'd9, 5'd0}; b_stg_RegWrite = 3'b010; b_stg_MemRead = 3'b010;
        @(negedge clk);
        check("fl_idle", b_stall, 0);
        check("fl_cnt", b_stall_cnt, 4);
        tick;
        // Flush beats a fresh hazard in IDLE
        b_load_in_ex;
        b_flush = 1;
        @(negedge clk);
        check("fl_prio", b_stall, 0);
        tick;
        b_flush = 0;

        // Continuous hazard: counter saturates at 15
        repeat (20) tick;
        @(negedge clk);
        check("sat_stall", b_stall, 1);
        check("sat_cnt", b_stall_cnt, 15);
        repeat (2) tick;
        @(negedge clk);
        check("sat_hold", b_stall_cnt, 15);

        // Reset mid-stall clears everything
        tick;
        reset = 1;
        tick;
        reset = 0;
        clear_a;
        clear_b;
        @(negedge clk);
        check("rst2_b_stall", b_stall, 0);
        check("rst2_b_cnt", b_stall_cnt, 0);
        check("rst2_a_err", a_fwd_err, 0);
        check("rst2_a_cnt", a_stall_cnt, 0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and load-use hazard controller for the in-order pipeline.
- Generalised in three ways:
  - N post-EX forwarding stages.
  - N source operands per instruction.
  - Configurable load latency.
- Adds a registered stall FSM that freezes IF/ID and injects EX bubbles for load-use hazards, plus a saturating stall-cycle counter and a sticky illegal-forward flag.
- Sits beside the ID/EX pipeline registers. Drives the EX operand muxes, the PC/IF-ID enables and the ID/EX bubble insert.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction (rs1, rs2, ...).
- NUM_STG, 2, forwarding stages after EX. Index 0 = EX/MEM (nearest), NUM_STG-1 = farthest (WB).
- LOAD_LAT, 1, load data forwardable only from stage index >= LOAD_LAT. Legal range 1..NUM_STG-1.
- CNT_W, 16, width of the stall counter.
- SEL_W (localparam) = $clog2(NUM_STG+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  NUM_SRC*REG_AW  ID source registers. Operand i occupies bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  operand i is actually read.
- ex_valid  in  1  EX holds a valid instruction.
- ex_rs  in  NUM_SRC*REG_AW  EX source registers.
- ex_rd  in  REG_AW  EX destination.
- ex_RegWrite  in  1  EX writes rd.
- ex_MemRead  in  1  EX instruction is a load.
- stg_rd  in  NUM_STG*REG_AW  destination of each post-EX stage.
- stg_RegWrite  in  NUM_STG  stage writes rd.
- stg_MemRead  in  NUM_STG  stage holds a load.
- flush  in  1  branch/jump redirect; kills ID and EX.
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = stage k-1.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- fwd_err  out  1  sticky: EX forwarded from a load not yet ready.

Behaviour:
- Reset values:
  - stall = 0, bubble = 0, stall_cnt = 0, fwd_err = 0.
  - FSM = IDLE, internal down-counter rem = 0.
  - fwd_sel is combinational; it reads 0 whenever ex_valid = 0.
- Forwarding (combinational, zero latency):
  - Stage k matches operand i when stg_RegWrite[k] = 1, stg_rd[k] != 0 and stg_rd[k] == ex_rs[i].
  - Lowest matching k wins, and fwd_sel[i] = k+1.
  - With no match, or ex_valid = 0, fwd_sel[i] = 0.
- Illegal forward:
  - Triggers when the winning stage k has stg_MemRead[k] = 1 and k < LOAD_LAT.
  - fwd_err is set on the next edge and stays set until reset.
  - fwd_sel still reports k+1.
- Load-use need, computed for each used ID operand:
  - If the EX instruction is a valid load (ex_valid, ex_RegWrite, ex_MemRead all 1) with ex_rd != 0 matching the operand: need = LOAD_LAT.
  - If stage j holds a load (stg_RegWrite[j] = 1, stg_MemRead[j] = 1) with rd != 0 matching the operand: need = LOAD_LAT-1-j, when this is > 0.
  - A non-load producer never contributes need; it is covered by forwarding.
  - N = maximum need across all operands and producers, or 0 if id_valid = 0.
- FSM:
  - IDLE:
    - stall = bubble = (N > 0) && !flush, Mealy.
    - If N > 1 && !flush: rem <= N-1, go to STALL.
  - STALL:
    - stall = bubble = 1. ID inputs are ignored; the stall is not re-evaluated.
    - rem decrements each cycle. Return to IDLE on the edge where rem == 1.
  - Net effect: stall is high for exactly N consecutive cycles per hazard.
- flush in any state:
  - stall = bubble = 0 in that same cycle.
  - Next state is IDLE with rem = 0.
  - flush has priority over hazard detection.
- reset mid-stall: next cycle is IDLE, outputs deasserted, counters cleared.
- stall_cnt increments by 1 on every edge where stall = 1 and reset = 0. It saturates at 2^CNT_W-1 and never wraps.
- x0 never causes forwarding or stalls.

Test Plan:
1. Defaults. EX add x5 (stg0 rd = 5, RegWrite); next instruction ex_rs = {5, 5}, with stg1 also rd = 5. -> fwd_sel = {1, 1}: nearest stage wins. Both fields 0 once ex_valid = 0.
2. LOAD_LAT = 1, load x7 in EX, ID reads rs2 = 7. -> stall = bubble = 1 for exactly 1 cycle, then 0; stall_cnt = 1. With id_rs_used[1] = 0: no stall.
3. NUM_STG = 3, LOAD_LAT = 2, load x9 in EX with an ID consumer. -> stall high 2 cycles (IDLE -> STALL -> IDLE); stall_cnt = 2. Load x9 in stg0 instead -> 1 stall cycle.
4. Scenario 3 with flush asserted in the second stall cycle. -> stall = 0 that cycle; FSM in IDLE next cycle; stall_cnt = 1.
5. stg0 holds load x3, LOAD_LAT = 1, EX reads x3 (hazard forced by bench). -> fwd_sel = 1 and fwd_err = 1 from the next cycle, staying 1 until reset.
6. CNT_W = 4, hold a hazard for 20 stall cycles. -> stall_cnt = 15 and stays 15. reset -> stall_cnt = 0, fwd_err = 0, stall = 0 on the following cycle.
